sdram_wr_burst_feeder: RTL and testbench
========================================

# sdram_wr_burst_feeder

Write-side front end for the SDRAM controller: collects a continuous 16-bit user data stream in an on-chip FIFO and, once a full-page burst is buffered, raises `wr_req` with a page-aligned address. It then streams exactly one burst of words on `wdata`, aligned to the controller's `wr_ack`. It sits directly upstream of the SDRAM controller's `wr_req`/`waddr`/`wdata`/`wr_ack` port and manages a ring of bursts per frame.

## Interface
- `BURST_LEN`, 256: words per burst; equals the controller full-page length. Power of two.
- `FIFO_DEPTH`, 512: FIFO depth in words. Power of two, ≥ 2×`BURST_LEN`.
- `BASE_ADDR`, 22'h000000: first burst address of a frame. Low log2(`BURST_LEN`) bits are zero.
- `BURST_NUM`, 1200: bursts per frame before the address returns to `BASE_ADDR`.
- `clk` input 1: system clock, same domain as the SDRAM controller.
- `rst_n` input 1: reset, asynchronous, active-low.
- `din` input 16: user write data.
- `din_vld` input 1: `din` valid this cycle. No backpressure.
- `clr` input 1: single-cycle request to flush the FIFO and restart the frame at `BASE_ADDR`.
- `wr_req` output 1: burst request to the controller. Registered.
- `waddr` output 22: burst start address as {bank[1:0], row[11:0], col[7:0]}. Registered; col is always 0.
- `wdata` output 16: current FIFO head (show-ahead).
- `wr_ack` input 1: single-cycle pulse from the controller; marks the cycle in which word 0 is consumed.
- `frame_done` output 1: single-cycle pulse after the last word of burst `BURST_NUM`-1 is popped.
- `ovf` output 1: sticky overflow flag. Cleared by reset or by an executed `clr`.
- `drop_cnt` output 16: dropped-word counter. See Configuration.

## Operation
- FIFO
  - Push when `din_vld` and (not full, or a pop occurs in the same cycle).
  - Pop in each burst cycle.
  - `fifo_cnt` is log2(`FIFO_DEPTH`)+1 bits wide, with the exact occupancy.
- FSM states: IDLE, REQ, BURST.
  - IDLE → REQ when `fifo_cnt` ≥ `BURST_LEN` and no clear is pending. `wr_req` is set to 1 on that edge.
  - REQ: `wr_req` and `waddr` are held stable until `wr_ack` = 1. On the `wr_ack` cycle, pop word 0, clear `wr_req`, set `beat` to 1, and move to BURST.
  - BURST: pop one word per cycle. `beat` is 8 bits and counts 1 .. `BURST_LEN`-1.
  - Leaving BURST: on the cycle `beat` = `BURST_LEN`-1, pop the last word and return to IDLE.
- Address update on BURST exit:
  - If `burst_idx` = `BURST_NUM`-1: `waddr` ← `BASE_ADDR`, `burst_idx` ← 0, pulse `frame_done`.
  - Otherwise: `waddr` ← `waddr` + `BURST_LEN` (modulo 2^22), `burst_idx` ← `burst_idx` + 1.
- Ignored `wr_ack`: a `wr_ack` seen in IDLE or BURST is ignored; it neither pops nor changes state.
- `clr` handling
  - In IDLE or REQ: takes effect at the next edge. Flush the FIFO, set `waddr` = `BASE_ADDR`, `burst_idx` = 0, deassert `wr_req`, go to IDLE, and clear `ovf`/`drop_cnt`.
  - `clr` coincident with `wr_ack` in REQ: the burst wins. Enter BURST and latch `clr_pend`.
  - In BURST: latch `clr_pend`. The burst completes normally and the clear executes on BURST exit, overriding the address increment and suppressing `frame_done`.
  - Pushes in the cycle the clear executes are discarded.
- Overflow: `din_vld` while full with no pop drops the word and sets `ovf`.

## Timing
- Reset values: `wr_req` = 0, `waddr` = `BASE_ADDR`, `frame_done` = 0, `ovf` = 0, `drop_cnt` = 0, FIFO empty. `wdata` shows the stale head value and is don't-care.
- `fifo_cnt` updates on the edge that accepts a word.
- Request latency: if the edge accepting the `BURST_LEN`-th word is E, `wr_req` is high after E+1.
- Data alignment: word k of the burst is on `wdata` in cycle (`wr_ack` cycle + k), k = 0 .. `BURST_LEN`-1. This is required by the controller, which drives `dq` combinationally from `wdata` during its write phase.
- Back-to-back bursts: IDLE is one cycle minimum, so the earliest next `wr_req` is 1 cycle after BURST exit.
- Refresh: an arbitrarily long REQ (controller refreshing or reading) is legal. The FIFO keeps absorbing input.
- Sustained rate: ≤ one word per cycle, limited by the controller's average service rate.

## Configuration
- `SDRAM_WR_DROP_CNT_EN` defined: `drop_cnt` increments on each dropped word, saturates at 16'hFFFF, and clears with `ovf`.
- `SDRAM_WR_DROP_CNT_EN` undefined: no counter logic; `drop_cnt` is tied to 16'h0000. `ovf` is always present.

## Test plan
- Single burst: push 256 words 0..255 back-to-back. Expect `wr_req` high 1 cycle after the last push with `waddr` = 0. Hold `wr_ack` off for 10 cycles, then pulse it. Expect `wdata` = 0..255 on cycles ack..ack+255, `wr_req` low in the cycle after ack, and final `waddr` = 22'h000100.
- Frame wrap (`BURST_NUM` = 2): push 512 words and ack both bursts. Expect `waddr` sequence 0x000000, 0x000100, then back to 0x000000, with `frame_done` pulsing once after the second burst's last word.
- Overflow: push 520 words with no `wr_ack`. Expect 8 words dropped, `ovf` = 1, `drop_cnt` = 8 (macro defined) or 0 (undefined). The first burst then returns words 0..255.
- Simultaneous push/pop at full: with the FIFO full, pulse `wr_ack` while `din_vld` = 1 continuously. Expect no drops and `fifo_cnt` to remain 512 throughout the burst.
- Clear mid-burst: pulse `clr` at beat 100. Expect the burst to complete with all 256 words, then the FIFO empty, `waddr` = `BASE_ADDR`, no `frame_done`, and `wr_req` low until 256 new words arrive.
- Reset mid-burst: deassert `rst_n` at beat 50. Expect all outputs at their reset values immediately and a FIFO count of 0 after release.

Source files
------------

// File: rtl/sdram_wr_burst_feeder_if.sv
// Burst write port between the feeder and the SDRAM controller.
interface sdram_wr_burst_feeder_if;
  logic        wr_req;
  logic [21:0] waddr;
  logic [15:0] wdata;
  logic        wr_ack;

  modport master (output wr_req, output waddr, output wdata, input wr_ack);
  modport slave  (input wr_req, input waddr, input wdata, output wr_ack);
endinterface

// File: rtl/sdram_wr_burst_feeder.sv
// SDRAM write burst feeder: buffers a 16-bit stream in a show-ahead FIFO and
// hands one full-page burst at a time to the controller, walking a ring of
// BURST_NUM burst addresses per frame.
// Optional feature: define SDRAM_WR_DROP_CNT_EN to build the saturating
// dropped-word counter; otherwise drop_cnt is tied to zero.
module sdram_wr_burst_feeder #(
  parameter int unsigned BURST_LEN  = 256,
  parameter int unsigned FIFO_DEPTH = 512,
  parameter logic [21:0] BASE_ADDR  = 22'h000000,
  parameter int unsigned BURST_NUM  = 1200
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [15:0]                    din,
  input  logic                           din_vld,
  input  logic                           clr,
  sdram_wr_burst_feeder_if.master        sdram,
  output logic                           frame_done,
  output logic                           ovf,
  output logic [15:0]                    drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(BURST_LEN);
  localparam int unsigned IW = (BURST_NUM > 1) ? $clog2(BURST_NUM) : 1;

  localparam logic [CW-1:0] FifoFull   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BurstWords = CW'(BURST_LEN);
  localparam logic [BW-1:0] LastBeat   = BW'(BURST_LEN - 1);
  localparam logic [IW-1:0] LastIdx    = IW'(BURST_NUM - 1);
  localparam logic [21:0]   AddrStep   = 22'(BURST_LEN);

  typedef enum logic [1:0] {StIdle, StReq, StBurst} state_e;

  state_e          state_q, state_d;
  logic            wr_req_q, wr_req_d;
  logic [21:0]     waddr_q, waddr_d;
  logic [IW-1:0]   burst_idx_q, burst_idx_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            clr_pend_q, clr_pend_d;
  logic            frame_done_q, frame_done_d;
  logic            ovf_q, ovf_d;

  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   fifo_cnt_q;

  logic            pop;
  logic            push;
  logic            drop;
  logic            clr_exec;
  logic            full;

  assign full = (fifo_cnt_q == FifoFull);

  // Burst sequencing, address ring, clear handling and FIFO push/drop decode.
  always_comb begin
    state_d      = state_q;
    wr_req_d     = wr_req_q;
    waddr_d      = waddr_q;
    burst_idx_d  = burst_idx_q;
    beat_d       = beat_q;
    clr_pend_d   = clr_pend_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    clr_exec     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clr) begin
          clr_exec = 1'b1;
        end else if (fifo_cnt_q >= BurstWords) begin
          state_d  = StReq;
          wr_req_d = 1'b1;
        end
      end
      StReq: begin
        // An ack always starts the burst; a coincident clear waits for its end.
        if (sdram.wr_ack) begin
          pop        = 1'b1;
          wr_req_d   = 1'b0;
          beat_d     = BW'(1);
          clr_pend_d = clr;
          state_d    = StBurst;
        end else if (clr) begin
          clr_exec = 1'b1;
        end
      end
      StBurst: begin
        pop    = 1'b1;
        beat_d = beat_q + BW'(1);
        if (clr) begin
          clr_pend_d = 1'b1;
        end
        if (beat_q == LastBeat) begin
          state_d = StIdle;
          if (clr_pend_q || clr) begin
            clr_exec = 1'b1;
          end else if (burst_idx_q == LastIdx) begin
            waddr_d      = BASE_ADDR;
            burst_idx_d  = '0;
            frame_done_d = 1'b1;
          end else begin
            waddr_d     = waddr_q + AddrStep;
            burst_idx_d = burst_idx_q + IW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (clr_exec) begin
      state_d     = StIdle;
      wr_req_d    = 1'b0;
      waddr_d     = BASE_ADDR;
      burst_idx_d = '0;
      clr_pend_d  = 1'b0;
    end

    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    push  = din_vld && (!full || pop) && !clr_exec;
    drop  = din_vld && full && !pop && !clr_exec;
    ovf_d = clr_exec ? 1'b0 : (ovf_q | drop);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_req_q     <= 1'b0;
      waddr_q      <= BASE_ADDR;
      burst_idx_q  <= '0;
      beat_q       <= '0;
      clr_pend_q   <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_req_q     <= wr_req_d;
      waddr_q      <= waddr_d;
      burst_idx_q  <= burst_idx_d;
      beat_q       <= beat_d;
      clr_pend_q   <= clr_pend_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
    end
  end

  // FIFO pointers and occupancy; an executed clear flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (clr_exec) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= din;
    end
  end

`ifdef SDRAM_WR_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of words lost to overflow, cleared together with ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (clr_exec) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'h0000;
`endif

  assign sdram.wr_req = wr_req_q;
  assign sdram.waddr  = waddr_q;
  assign sdram.wdata  = mem[rd_ptr_q];
  assign frame_done   = frame_done_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_sdram_wr_burst_feeder.sv
// Self-checking bench for sdram_wr_burst_feeder with a queue-based reference
// model of the FIFO, request/burst handshake and address ring (BURST_NUM = 2).
module tb_sdram_wr_burst_feeder;

  localparam int unsigned BL   = 256;
  localparam int unsigned FD   = 512;
  localparam int unsigned BN   = 2;
  localparam logic [21:0] BASE = 22'h000000;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        din_vld;
  logic        clr;
  logic        frame_done;
  logic        ovf;
  logic [15:0] drop_cnt;

  sdram_wr_burst_feeder_if bus ();

  sdram_wr_burst_feeder #(
    .BURST_LEN (BL),
    .FIFO_DEPTH(FD),
    .BASE_ADDR (BASE),
    .BURST_NUM (BN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .clr       (clr),
    .sdram     (bus),
    .frame_done(frame_done),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model state
  int          mq[$];
  bit          m_req;
  int          m_left;
  bit          m_pend;
  int          m_idx;
  logic [21:0] m_addr;
  bit          m_ovf;
  int          m_drops;
  bit          m_fd;

  function automatic logic [15:0] exp_drop();
`ifdef SDRAM_WR_DROP_CNT_EN
    return 16'(m_drops);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_req = 0; m_left = 0; m_pend = 0; m_idx = 0;
    m_addr = BASE; m_ovf = 0; m_drops = 0; m_fd = 0;
  endtask

  // Apply the current inputs to the model, then advance one clock.
  task automatic step();
    int sz;
    int unused;
    bit pop, full, cexec;
    sz    = mq.size();
    pop   = (m_req && bus.wr_ack) || (m_left > 0);
    full  = (sz == FD);
    cexec = (m_left == 0 && clr && !(m_req && bus.wr_ack)) || (m_left == 1 && (m_pend || clr));
    m_fd  = 0;
    if (pop && sz > 0) unused = mq.pop_front();
    if (din_vld && !cexec) begin
      if (!full || pop) mq.push_back(int'(din));
      else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
    if (m_left > 0) begin
      m_left--;
      if (m_left > 0) begin
        if (clr) m_pend = 1;
      end else if (!cexec) begin
        if (m_idx == BN - 1) begin
          m_idx = 0; m_addr = BASE; m_fd = 1;
        end else begin
          m_idx++; m_addr = m_addr + 22'(BL);
        end
      end
    end else if (m_req && bus.wr_ack) begin
      m_req = 0; m_left = BL - 1; m_pend = clr;
    end else if (!m_req && sz >= BL) begin
      m_req = 1;
    end
    if (cexec) begin
      mq.delete();
      m_addr = BASE; m_idx = 0; m_req = 0; m_ovf = 0; m_drops = 0; m_pend = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; din = '0; din_vld = 0; clr = 0; bus.wr_ack = 0;
    model_reset();
    #3;
    n_checks++;
    if (bus.wr_req !== 1'b0) begin n_fail++; $display("FAIL reset_wr_req got %0b want 0", bus.wr_req); end
    n_checks++;
    if (bus.waddr !== BASE) begin n_fail++; $display("FAIL reset_waddr got %h want %h", bus.waddr, BASE); end
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %0b want 0", frame_done); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", ovf); end
    n_checks++;
    if (drop_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_drop_cnt got %h want 0", drop_cnt); end
    n_checks++;
    if (dut.fifo_cnt_q !== 10'd0) begin n_fail++; $display("FAIL reset_fifo_cnt got %0d want 0", dut.fifo_cnt_q); end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_burst();
    for (int k = 0; k < 256; k++) begin
      din = 16'(k); din_vld = 1; step();
    end
    din_vld = 0;
    n_checks++;
    if (bus.wr_req !== 1'b0) begin n_fail++; $display("FAIL single_req_early got %0b want 0", bus.wr_req); end
    step();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (bus.wr_req !== 1'b1 || bus.waddr !== 22'h0) begin
        n_fail++; $display("FAIL single_req_hold req %0b addr %h want 1 000000", bus.wr_req, bus.waddr);
      end
      step();
    end
    bus.wr_ack = 1;
    for (int k = 0; k < 256; k++) begin
      n_checks++;
      if (bus.wdata !== 16'(k)) begin n_fail++; $display("FAIL single_wdata k=%0d got %h want %h", k, bus.wdata, 16'(k)); end
      step();
      bus.wr_ack = 0;
      if (k == 0) begin
        n_checks++;
        if (bus.wr_req !== 1'b0) begin n_fail++; $display("FAIL single_req_after_ack got %0b want 0", bus.wr_req); end
      end
    end
    n_checks++;
    if (bus.waddr !== 22'h000100) begin n_fail++; $display("FAIL single_final_waddr got %h want 000100", bus.waddr); end
    n_checks++;
    if (dut.fifo_cnt_q !== 10'd0) begin n_fail++; $display("FAIL single_fifo_empty got %0d want 0", dut.fifo_cnt_q); end
  endtask

  task automatic test_frame_wrap();
    logic [21:0] want_a;
    for (int b = 0; b < 2; b++) begin
      for (int n = 0; n < 256; ) begin
        din = 16'($urandom); din_vld = ($urandom_range(0, 3) != 0);
        if (din_vld) n++;
        step();
      end
      din_vld = 0;
      for (int i = 0; i < 20 && bus.wr_req !== 1'b1; i++) step();
      want_a = (b == 0) ? 22'h000100 : 22'h000000;
      n_checks++;
      if (bus.wr_req !== 1'b1 || bus.waddr !== want_a || bus.waddr !== m_addr) begin
        n_fail++; $display("FAIL wrap_req b=%0d req %0b addr %h want 1 %h", b, bus.wr_req, bus.waddr, want_a);
      end
      repeat ($urandom_range(0, 15)) step();
      for (int k = 0; k < 256; k++) begin
        bus.wr_ack = (k == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
        n_checks++;
        if (mq.size() == 0 || bus.wdata !== 16'(mq[0])) begin
          n_fail++; $display("FAIL wrap_wdata b=%0d k=%0d got %h", b, k, bus.wdata);
        end
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL wrap_fd_early b=%0d k=%0d got 1 want 0", b, k); end
        step();
      end
      bus.wr_ack = 0;
      n_checks++;
      if (frame_done !== m_fd || frame_done !== (b == 0)) begin
        n_fail++; $display("FAIL wrap_frame_done b=%0d got %0b want %0b", b, frame_done, m_fd);
      end
      n_checks++;
      want_a = (b == 0) ? 22'h000000 : 22'h000100;
      if (bus.waddr !== want_a) begin n_fail++; $display("FAIL wrap_next_addr b=%0d got %h want %h", b, bus.waddr, want_a); end
      step();
      n_checks++;
      if (frame_done !== 1'b0) begin n_fail++; $display("FAIL wrap_fd_pulse b=%0d got 1 want 0", b); end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] words[$];
    for (int k = 0; k < 520; k++) begin
      din = 16'($urandom); din_vld = 1;
      words.push_back(din);
      if (k == 512) begin
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got 1 want 0"); end
      end
      step();
    end
    din_vld = 0;
    n_checks++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", ovf); end
    n_checks++;
`ifdef SDRAM_WR_DROP_CNT_EN
    if (drop_cnt !== 16'd8 || m_drops != 8) begin n_fail++; $display("FAIL ovf_drop_cnt got %0d want 8", drop_cnt); end
`else
    if (drop_cnt !== 16'd0 || m_drops != 8) begin n_fail++; $display("FAIL ovf_drop_cnt got %0d want 0", drop_cnt); end
`endif
    n_checks++;
    if (dut.fifo_cnt_q !== 10'd512) begin n_fail++; $display("FAIL ovf_fifo_cnt got %0d want 512", dut.fifo_cnt_q); end
    bus.wr_ack = 1;
    for (int k = 0; k < 256; k++) begin
      n_checks++;
      if (bus.wdata !== words[k]) begin n_fail++; $display("FAIL ovf_wdata k=%0d got %h want %h", k, bus.wdata, words[k]); end
      step();
      bus.wr_ack = 0;
    end
  endtask

  task automatic test_full_push_pop();
    for (int k = 0; k < 256; k++) begin
      din = 16'($urandom); din_vld = 1; step();
    end
    n_checks++;
    if (dut.fifo_cnt_q !== 10'd512 || bus.wr_req !== 1'b1) begin
      n_fail++; $display("FAIL full_setup cnt %0d req %0b want 512 1", dut.fifo_cnt_q, bus.wr_req);
    end
    bus.wr_ack = 1;
    for (int k = 0; k < 256; k++) begin
      din = 16'($urandom); din_vld = 1;
      n_checks++;
      if (bus.wdata !== 16'(mq[0])) begin n_fail++; $display("FAIL full_wdata k=%0d got %h want %h", k, bus.wdata, 16'(mq[0])); end
      step();
      bus.wr_ack = 0;
      n_checks++;
      if (dut.fifo_cnt_q !== 10'd512) begin n_fail++; $display("FAIL full_fifo_cnt k=%0d got %0d want 512", k, dut.fifo_cnt_q); end
    end
    din_vld = 0;
    n_checks++;
    if (drop_cnt !== exp_drop() || m_drops != 8) begin
      n_fail++; $display("FAIL full_no_drops got %0d want %0d", drop_cnt, exp_drop());
    end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 20 && bus.wr_req !== 1'b1; i++) step();
    n_checks++;
    if (bus.wr_req !== 1'b1) begin n_fail++; $display("FAIL clr_req_wait got %0b want 1", bus.wr_req); end
    bus.wr_ack = 1;
    for (int k = 0; k < 256; k++) begin
      clr = (k == 100);
      n_checks++;
      if (bus.wdata !== 16'(mq[0])) begin n_fail++; $display("FAIL clr_wdata k=%0d got %h want %h", k, bus.wdata, 16'(mq[0])); end
      step();
      bus.wr_ack = 0;
    end
    clr = 0;
    n_checks++;
    if (dut.fifo_cnt_q !== 10'd0 || bus.waddr !== BASE || bus.wr_req !== 1'b0) begin
      n_fail++; $display("FAIL clr_after cnt %0d addr %h req %0b want 0 %h 0", dut.fifo_cnt_q, bus.waddr, bus.wr_req, BASE);
    end
    n_checks++;
    if (frame_done !== 1'b0 || ovf !== 1'b0 || drop_cnt !== 16'h0) begin
      n_fail++; $display("FAIL clr_flags fd %0b ovf %0b drop %0d want 0 0 0", frame_done, ovf, drop_cnt);
    end
    for (int k = 0; k < 255; k++) begin
      din = 16'($urandom); din_vld = 1; step();
    end
    din_vld = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus.wr_req !== 1'b0) begin n_fail++; $display("FAIL clr_req_255 got 1 want 0"); end
    end
    din = 16'($urandom); din_vld = 1; step(); din_vld = 0; step();
    n_checks++;
    if (bus.wr_req !== 1'b1 || bus.waddr !== BASE) begin
      n_fail++; $display("FAIL clr_req_256 req %0b addr %h want 1 %h", bus.wr_req, bus.waddr, BASE);
    end
    // Clear while a request is outstanding
    clr = 1; step(); clr = 0;
    n_checks++;
    if (bus.wr_req !== 1'b0 || dut.fifo_cnt_q !== 10'd0) begin
      n_fail++; $display("FAIL clr_in_req req %0b cnt %0d want 0 0", bus.wr_req, dut.fifo_cnt_q);
    end
    for (int k = 0; k < 256; k++) begin
      din = 16'($urandom); din_vld = 1; step();
    end
    din_vld = 0; step();
    // Clear coincident with ack: the burst still runs to completion
    bus.wr_ack = 1; clr = 1;
    for (int k = 0; k < 256; k++) begin
      n_checks++;
      if (mq.size() == 0 || bus.wdata !== 16'(mq[0])) begin n_fail++; $display("FAIL clr_ack_wdata k=%0d got %h", k, bus.wdata); end
      step();
      bus.wr_ack = 0; clr = 0;
      din = 16'($urandom); din_vld = ($urandom_range(0, 1) == 1);
    end
    din_vld = 0;
    n_checks++;
    if (dut.fifo_cnt_q !== 10'd0 || bus.wr_req !== 1'b0 || bus.waddr !== BASE || m_req) begin
      n_fail++; $display("FAIL clr_ack_after cnt %0d req %0b addr %h want 0 0 %h", dut.fifo_cnt_q, bus.wr_req, bus.waddr, BASE);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int k = 0; k < 512; k++) begin
      din = 16'($urandom); din_vld = 1; step();
    end
    din_vld = 0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 20 && bus.wr_req !== 1'b1; i++) step();
      n_checks++;
      if (bus.wr_req !== 1'b1 || bus.waddr !== m_addr) begin
        n_fail++; $display("FAIL rst_req b=%0d req %0b addr %h want 1 %h", b, bus.wr_req, bus.waddr, m_addr);
      end
      bus.wr_ack = 1;
      for (int k = 0; k < ((b == 0) ? 256 : 50); k++) begin
        n_checks++;
        if (bus.wdata !== 16'(mq[0])) begin n_fail++; $display("FAIL rst_wdata b=%0d k=%0d got %h", b, k, bus.wdata); end
        step();
        bus.wr_ack = 0;
      end
    end
    n_checks++;
    if (bus.waddr !== 22'h000100) begin n_fail++; $display("FAIL rst_pre_addr got %h want 000100", bus.waddr); end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if (bus.wr_req !== 1'b0 || bus.waddr !== BASE || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_async req %0b addr %h fd %0b want 0 %h 0", bus.wr_req, bus.waddr, frame_done, BASE);
    end
    n_checks++;
    if (ovf !== 1'b0 || drop_cnt !== 16'h0 || dut.fifo_cnt_q !== 10'd0) begin
      n_fail++; $display("FAIL rst_async_fifo ovf %0b drop %0d cnt %0d want 0", ovf, drop_cnt, dut.fifo_cnt_q);
    end
    @(negedge clk);
    rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;
    step();
    n_checks++;
    if (dut.fifo_cnt_q !== 10'd0 || bus.wr_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_release cnt %0d req %0b want 0 0", dut.fifo_cnt_q, bus.wr_req);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_burst();
    test_frame_wrap();
    test_overflow();
    test_full_push_pop();
    test_clr();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
